uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 72 +++++++
 tb/tb_uart_tx.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: transmit request/status bundle between a byte source and the UART transmitter.
interface uart_tx_if;
    logic       i_tx_start;
    logic [7:0] i_tx_d;
    logic       o_tx_d;
    logic       o_tx_busy;
    logic       o_tx_done;
    modport master (output i_tx_start, i_tx_d, input o_tx_d, o_tx_busy, o_tx_done);
    modport slave  (input i_tx_start, i_tx_d, output o_tx_d, o_tx_busy, o_tx_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, each bit held CLKS_PER_BIT clocks, registered line/busy/done.
module uart_tx #(
    parameter int SYS_CLK   = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input logic     clk,
    input logic     rst_n,
    uart_tx_if.slave tx
);
    localparam int CLKS_PER_BIT = SYS_CLK / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      sh;
    logic            tc;
    assign tc = cnt == CW'(CLKS_PER_BIT - 1);
    // Outputs are registered with the value of the state being entered, so the line moves in step with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            sh           <= '0;
            tx.o_tx_d    <= 1'b1;
            tx.o_tx_busy <= 1'b0;
            tx.o_tx_done <= 1'b0;
        end else begin
            tx.o_tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt          <= '0;
                    tx.o_tx_d    <= 1'b1;
                    tx.o_tx_busy <= 1'b0;
                    if (tx.i_tx_start) begin
                        sh           <= tx.i_tx_d;
                        idx          <= '0;
                        state        <= START;
                        tx.o_tx_d    <= 1'b0;
                        tx.o_tx_busy <= 1'b1;
                    end
                end
                START: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        state     <= DATA;
                        tx.o_tx_d <= sh[0];
                    end
                end
                DATA: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        sh        <= sh >> 1;
                        idx       <= idx + 1'b1;
                        state     <= idx == 3'd7 ? STOP : DATA;
                        tx.o_tx_d <= idx == 3'd7 ? 1'b1 : sh[1];
                    end
                end
                default: begin
                    cnt <= tc ? '0 : cnt + 1'b1;
                    if (tc) begin
                        state        <= IDLE;
                        tx.o_tx_d    <= 1'b1;
                        tx.o_tx_busy <= 1'b0;
                        tx.o_tx_done <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frames checked every cycle against a per-cycle waveform model, plus literal frame decodes.
module tb_uart_tx;
    localparam int CPB = 16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cyc = 0;
    logic [2:0] q[$];
    uart_tx_if bus();
    uart_tx #(.SYS_CLK(1600000), .BAUD_RATE(100000)) dut (.clk(clk), .rst_n(rst_n), .tx(bus));
    always #5 clk = ~clk;

    // Model: an accepted byte expands into its full expected waveform of {line, busy, done} per cycle.
    always @(posedge clk) begin
        if (rst_n && bus.i_tx_start && q.size() == 0) begin
            for (int k = 0; k < 10 * CPB; k++) begin
                int b;
                logic ln;
                b = k / CPB;
                ln = b == 0 ? 1'b0 : b == 9 ? 1'b1 : bus.i_tx_d[b-1];
                q.push_back({ln, 1'b1, 1'b0});
            end
            q.push_back(3'b101);
        end
    end
    always @(negedge rst_n) q.delete();

    always @(negedge clk) begin
        logic [2:0] e;
        logic [2:0] a;
        e = q.size() != 0 ? q.pop_front() : 3'b100;
        a = {bus.o_tx_d, bus.o_tx_busy, bus.o_tx_done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle_model t=%0t line/busy/done actual %b expected %b", $time, a, e);
        end
        done_cnt += bus.o_tx_done === 1'b1 ? 1 : 0;
        busy_cyc += bus.o_tx_busy === 1'b1 ? 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input logic [7:0] d);
        @(negedge clk); #2;
        bus.i_tx_start = 1'b1;
        bus.i_tx_d = d;
        @(negedge clk); #2;
        bus.i_tx_start = 1'b0;
    endtask

    task automatic recv(output logic [7:0] d);
        int n;
        d = 8'h00;
        n = 0;
        @(negedge clk);
        while (bus.o_tx_d !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            errors++;
            $display("FAIL recv_timeout no start bit seen");
        end else begin
            repeat (7) @(negedge clk);
            chk("start_bit", bus.o_tx_d, 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = bus.o_tx_d;
            end
            repeat (CPB) @(negedge clk);
            chk("stop_bit", bus.o_tx_d, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.o_tx_busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            errors++;
            $display("FAIL idle_timeout busy never dropped");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        int n;
        bus.i_tx_start = 1'b0;
        bus.i_tx_d = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_line", bus.o_tx_d, 1);
        chk("reset_busy", bus.o_tx_busy, 0);
        #2 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("idle_done_count", done_cnt, 0);

        busy_cyc = 0; done_cnt = 0;
        pulse(8'hA5);
        recv(r);
        chk("frame_a5", r, 8'hA5);
        wait_idle();
        chk("a5_busy_cycles", busy_cyc, 160);
        chk("a5_done_count", done_cnt, 1);

        done_cnt = 0;
        for (int c = 0; c <= 200; c++) begin
            @(negedge clk); #2;
            bus.i_tx_start = c == 0 || c == 40 || c == 100;
            bus.i_tx_d = c == 0 ? 8'h3C : 8'hFF;
        end
        bus.i_tx_start = 1'b0;
        wait_idle();
        chk("ignore_start_done_count", done_cnt, 1);

        done_cnt = 0; busy_cyc = 0;
        @(negedge clk); #2;
        bus.i_tx_start = 1'b1;
        bus.i_tx_d = 8'h00;
        n = 0;
        while (bus.o_tx_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_done_seen", n < 400, 1);
        #2 bus.i_tx_d = 8'hFF;
        @(negedge clk);
        chk("b2b_no_gap_line", bus.o_tx_d, 0);
        #2 bus.i_tx_start = 1'b0;
        wait_idle();
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_busy_cycles", busy_cyc, 320);

        done_cnt = 0;
        pulse(8'h55);
        repeat (68) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_line", bus.o_tx_d, 1);
        chk("async_reset_busy", bus.o_tx_busy, 0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.i_tx_start = 1'b1;
        bus.i_tx_d = 8'h81;
        @(negedge clk); #2;
        bus.i_tx_start = 1'b0;
        chk("restart_line_low", bus.o_tx_d, 0);
        recv(r);
        chk("frame_81_after_reset", r, 8'h81);
        wait_idle();
        chk("reset_abort_done_count", done_cnt, 1);

        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            pulse(b);
            fork
                recv(r);
                repeat (100) begin
                    @(negedge clk); #2;
                    bus.i_tx_d = 8'($urandom);
                    bus.i_tx_start = 1'($urandom_range(0, 1));
                end
            join
            bus.i_tx_start = 1'b0;
            chk("random_frame", r, b);
            wait_idle();
        end
        chk("random_done_count", done_cnt, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
